// File: rtl/uart_tx_responder.sv
// ---------------------------------------------------------------------------
// uart_tx_responder
//
// Memory-mapped UART transmitter that sits on the CPU data-memory bus as a
// responder. Software pushes bytes into a small TX FIFO through TXDATA; a
// bit-timing FSM pops them and serialises each one as start, 8 data bits
// (LSB first), optional parity, and stop.
//
// Register map (addr[3:2]):
//   0x0 TXDATA  W: push data_i[7:0] when any sel_i lane is set. Reads 0.
//   0x4 STATUS  R: bit4 ovf, bit3 busy, bit2 empty, bit1 full, bit0 0.
//               W: a 1 in bit4 clears ovf.
//   0x8 DIVISOR R/W [15:0], byte lanes via sel_i[1:0]. Bit period = DIVISOR+1.
//   0xC CTRL    R/W bit0 tx_en, bit1 irq_en (bit2 parity en, bit3 odd when
//               UART_TX_PARITY_EN is defined), written via sel_i[0].
//
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   ce_i    bus access enable
//   we_i    1 = write, 0 = read
//   addr_i  byte address; [31:4] window compare, [3:2] register select
//   sel_i   byte-lane enables, bit0 = data[7:0]
//   data_i  write data
//   data_o  combinational read data, zero unless a read hits this block
//   hit_o   ce_i and address inside this block's window
//   txd_o   registered serial output, idle high
//   irq_o   registered level interrupt: irq_en & empty & !busy
//
// Build options:
//   UART_TX_PARITY_EN   adds the PARITY state and CTRL[3:2]
//   UART_TX_IRQ_OVF_EN  lets a sticky overflow also raise irq_o
// ---------------------------------------------------------------------------
module uart_tx_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    output logic        txd_o,
    output logic        irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- bus decode ----------------
    logic       wr_en;
    logic       rd_en;
    logic [1:0] reg_sel;

    assign hit_o   = ce_i && (addr_i[31:4] == BASE_ADDR[31:4]);
    assign wr_en   = hit_o && we_i;
    assign rd_en   = hit_o && !we_i;
    assign reg_sel = addr_i[3:2];

    // ---------------- register storage ----------------
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q, ovf_d;
    logic [15:0]   divisor_q, divisor_d;
    logic [3:0]    ctrl_q, ctrl_d;

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [15:0]   bit_div_q, bit_div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bit_q, par_bit_d;
    logic          par_on_q, par_on_d;
    logic          txd_q, txd_d;
    logic          irq_q, irq_d;

    logic fifo_empty, fifo_full, busy;
    logic push_req, push, pop, ovf_set, bit_end;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign busy       = (state_q != S_IDLE);

    // The pop is the IDLE->START transition itself, so it is known in the same
    // cycle as any push and lets a push into a full FIFO through.
    assign pop      = (state_q == S_IDLE) && ctrl_q[0] && !fifo_empty;
    assign push_req = wr_en && (reg_sel == 2'd0) && (sel_i != 4'b0000);
    assign push     = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && !push;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // ---------------- configuration registers ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div_lane
            assign divisor_d[gi*8 +: 8] =
                (wr_en && (reg_sel == 2'd2) && sel_i[gi]) ? data_i[gi*8 +: 8]
                                                          : divisor_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && (reg_sel == 2'd3) && sel_i[0]) begin
`ifdef UART_TX_PARITY_EN
            ctrl_d = data_i[3:0];
`else
            ctrl_d = {2'b00, data_i[1:0]};
`endif
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && (reg_sel == 2'd1) && data_i[4]) ovf_d = 1'b0;
        if (ovf_set)                                 ovf_d = 1'b1;
    end

    // ---------------- bit-timing FSM ----------------
    assign bit_end = (baud_q == bit_div_q);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_div_d = bit_div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        par_on_d  = par_on_q;

        if (state_q == S_IDLE) begin
            if (pop) begin
                state_d   = S_START;
                shift_d   = fifo_mem_q[rd_ptr_q];
                baud_d    = '0;
                bit_div_d = divisor_q;
                bit_d     = '0;
                // Parity config is captured per frame so a CTRL write
                // mid-frame cannot change the current frame's length.
                par_on_d  = ctrl_q[2];
                par_bit_d = (^fifo_mem_q[rd_ptr_q]) ^ ctrl_q[3];
            end
        end else if (bit_end) begin
            // Divisor is re-sampled at every bit boundary.
            baud_d    = '0;
            bit_div_d = divisor_q;
            unique case (state_q)
                S_START: state_d = S_DATA;
                S_DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_on_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end else begin
            baud_d = baud_q + 16'd1;
        end
    end

    // txd is derived from the next state so the line changes on the same edge
    // the FSM enters a bit.
    always_comb begin
        unique case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_bit_d;
            default:  txd_d = 1'b1;
        endcase
    end

`ifdef UART_TX_IRQ_OVF_EN
    assign irq_d = (ctrl_q[1] && fifo_empty && !busy) || ovf_q;
`else
    assign irq_d = ctrl_q[1] && fifo_empty && !busy;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_div_q <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            par_on_q  <= 1'b0;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
            ovf_q     <= 1'b0;
            divisor_q <= DIV_RESET;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_div_q <= bit_div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            par_on_q  <= par_on_d;
            txd_q     <= txd_d;
            irq_q     <= irq_d;
            ovf_q     <= ovf_d;
            divisor_q <= divisor_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign txd_o = txd_q;
    assign irq_o = irq_q;

    // ---------------- read mux ----------------
    always_comb begin
        data_o = '0;
        if (rd_en) begin
            unique case (reg_sel)
                2'd1:    data_o[4:0]  = {ovf_q, busy, fifo_empty, fifo_full, 1'b0};
                2'd2:    data_o[15:0] = divisor_q;
                2'd3:    data_o[3:0]  = ctrl_q;
                default: data_o       = '0;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], data_i[31:16]};

endmodule
